// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: classifies retired instructions into trace records, buffers them in a FIFO and signals end of test
module commit_trace_buffer #(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter logic [31:0] HALT_INSTR = 32'h0000006f
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       commit_valid_i,
  input  logic [XLEN-1:0]            commit_pc_i,
  input  logic [31:0]                commit_instr_i,
  input  logic [4:0]                 commit_rd_i,
  input  logic [XLEN-1:0]            commit_rd_data_i,
  input  logic                       commit_rd_we_i,
  input  logic                       commit_mem_re_i,
  input  logic                       commit_mem_we_i,
  input  logic [XLEN-1:0]            commit_mem_addr_i,
  input  logic [XLEN-1:0]            commit_mem_wdata_i,
  input  logic [1:0]                 commit_mem_size_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [1:0]                 trace_kind_o,
  output logic [XLEN-1:0]            trace_pc_o,
  output logic [31:0]                trace_instr_o,
  output logic [4:0]                 trace_rd_o,
  output logic [XLEN-1:0]            trace_data_o,
  output logic [XLEN-1:0]            trace_addr_o,
  output logic [1:0]                 trace_size_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [15:0]                drop_count_o,
  output logic                       halt_o,
  output logic                       timeout_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic cause_to, cause_to_nxt;
  logic [31:0] cnt;
  logic [AW-1:0] wptr, rptr;
  logic [1:0] kind_m [DEPTH];
  logic [XLEN-1:0] pc_m [DEPTH];
  logic [31:0] instr_m [DEPTH];
  logic [4:0] rd_m [DEPTH];
  logic [XLEN-1:0] data_m [DEPTH];
  logic [XLEN-1:0] addr_m [DEPTH];
  logic [1:0] size_m [DEPTH];
  logic cap, full, pop, push, drop, halt_hit, to_hit;
  logic [1:0] kind;
  logic [XLEN-1:0] sdata;
  assign cap = state == RUN && commit_valid_i && commit_pc_i != '0;
  assign kind = commit_mem_we_i ? 2'd3 :
                (commit_mem_re_i && commit_rd_i != '0) ? 2'd2 :
                (commit_rd_we_i && commit_rd_i != '0) ? 2'd1 : 2'd0;
  assign sdata = commit_mem_size_i == 2'd0 ? {{(XLEN-8){1'b0}}, commit_mem_wdata_i[7:0]} :
                 commit_mem_size_i == 2'd1 ? {{(XLEN-16){1'b0}}, commit_mem_wdata_i[15:0]} :
                 commit_mem_wdata_i;
  assign trace_valid_o = level_o != '0;
  assign pop = trace_valid_o && trace_ready_i;
  assign full = level_o == (AW+1)'(DEPTH);
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;
  assign halt_hit = cap && commit_instr_i == HALT_INSTR;
  assign to_hit = TIMEOUT_CYCLES != 0 && cnt == 32'(TIMEOUT_CYCLES - 1);
  assign trace_kind_o = trace_valid_o ? kind_m[rptr] : '0;
  assign trace_pc_o = trace_valid_o ? pc_m[rptr] : '0;
  assign trace_instr_o = trace_valid_o ? instr_m[rptr] : '0;
  assign trace_rd_o = trace_valid_o ? rd_m[rptr] : '0;
  assign trace_data_o = trace_valid_o ? data_m[rptr] : '0;
  assign trace_addr_o = trace_valid_o ? addr_m[rptr] : '0;
  assign trace_size_o = trace_valid_o ? size_m[rptr] : '0;
  assign halt_o = state == DONE && !cause_to;
  assign timeout_o = state == DONE && cause_to;
  always_comb begin
    state_nxt = state;
    cause_to_nxt = cause_to;
    case (state)
      RUN: if (halt_hit || to_hit) begin
        state_nxt = DRAIN;
        cause_to_nxt = !halt_hit;
      end
      DRAIN: if (level_o == '0) state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cause_to <= 1'b0;
      cnt <= '0;
      wptr <= '0;
      rptr <= '0;
      level_o <= '0;
      drop_count_o <= '0;
    end else begin
      state <= state_nxt;
      cause_to <= cause_to_nxt;
      if (state == RUN) cnt <= cnt + 32'd1;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (push != pop) level_o <= push ? level_o + 1'b1 : level_o - 1'b1;
      if (drop && drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      kind_m[wptr] <= kind;
      pc_m[wptr] <= commit_pc_i;
      instr_m[wptr] <= commit_instr_i;
      rd_m[wptr] <= (kind == 2'd1 || kind == 2'd2) ? commit_rd_i : '0;
      data_m[wptr] <= kind == 2'd3 ? sdata : kind == 2'd0 ? '0 : commit_rd_data_i;
      addr_m[wptr] <= kind[1] ? commit_mem_addr_i : '0;
      size_m[wptr] <= kind == 2'd3 ? commit_mem_size_i : '0;
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed stimulus with a queue-based reference model checked every cycle
module tb_commit_trace_buffer;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int TO = 50;
  localparam logic [31:0] HALT = 32'h0000006f;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic commit_valid_i, commit_rd_we_i, commit_mem_re_i, commit_mem_we_i, trace_ready_i;
  logic [31:0] commit_pc_i, commit_instr_i, commit_rd_data_i, commit_mem_addr_i, commit_mem_wdata_i;
  logic [4:0] commit_rd_i;
  logic [1:0] commit_mem_size_i;
  logic trace_valid_o, halt_o, timeout_o;
  logic [1:0] trace_kind_o, trace_size_o;
  logic [31:0] trace_pc_o, trace_instr_o, trace_data_o, trace_addr_o;
  logic [4:0] trace_rd_o;
  logic [$clog2(DEPTH):0] level_o;
  logic [15:0] drop_count_o;
  always #5 clk = ~clk;
  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .HALT_INSTR(HALT)) dut (
    .clk(clk), .rst(rst),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i),
    .commit_rd_i(commit_rd_i), .commit_rd_data_i(commit_rd_data_i), .commit_rd_we_i(commit_rd_we_i),
    .commit_mem_re_i(commit_mem_re_i), .commit_mem_we_i(commit_mem_we_i),
    .commit_mem_addr_i(commit_mem_addr_i), .commit_mem_wdata_i(commit_mem_wdata_i),
    .commit_mem_size_i(commit_mem_size_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i), .trace_kind_o(trace_kind_o),
    .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o), .trace_rd_o(trace_rd_o),
    .trace_data_o(trace_data_o), .trace_addr_o(trace_addr_o), .trace_size_o(trace_size_o),
    .level_o(level_o), .drop_count_o(drop_count_o), .halt_o(halt_o), .timeout_o(timeout_o)
  );
  typedef struct packed {
    logic [1:0] kind;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0] rd;
    logic [31:0] data;
    logic [31:0] addr;
    logic [1:0] size;
  } rec_t;
  rec_t q[$];
  int mode = 0;
  int cyc = 0;
  int drops = 0;
  bit to_cause = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] last_instr;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic rec_t mk();
    rec_t r;
    logic rd_nz;
    rd_nz = commit_rd_i != 5'd0;
    r = '0;
    r.pc = commit_pc_i;
    r.instr = commit_instr_i;
    if (commit_mem_we_i) begin
      r.kind = 2'd3;
      r.addr = commit_mem_addr_i;
      r.size = commit_mem_size_i;
      case (commit_mem_size_i)
        2'd0: r.data = commit_mem_wdata_i & 32'h000000FF;
        2'd1: r.data = commit_mem_wdata_i & 32'h0000FFFF;
        default: r.data = commit_mem_wdata_i;
      endcase
    end else if (commit_mem_re_i && rd_nz) begin
      r.kind = 2'd2;
      r.rd = commit_rd_i;
      r.data = commit_rd_data_i;
      r.addr = commit_mem_addr_i;
    end else if (commit_rd_we_i && rd_nz) begin
      r.kind = 2'd1;
      r.rd = commit_rd_i;
      r.data = commit_rd_data_i;
    end
    return r;
  endfunction
  always @(negedge clk) begin
    rec_t h;
    int n;
    bit p, c;
    h = q.size() > 0 ? q[0] : '0;
    chk("valid", trace_valid_o, q.size() > 0);
    chk("kind", trace_kind_o, h.kind);
    chk("pc", trace_pc_o, h.pc);
    chk("instr", trace_instr_o, h.instr);
    chk("rd", trace_rd_o, h.rd);
    chk("data", trace_data_o, h.data);
    chk("addr", trace_addr_o, h.addr);
    chk("size", trace_size_o, h.size);
    chk("level", level_o, q.size());
    chk("drops", drop_count_o, drops);
    chk("halt", halt_o, mode == 2 && !to_cause);
    chk("timeout", timeout_o, mode == 2 && to_cause);
    if (rst) begin
      q.delete();
      mode = 0;
      cyc = 0;
      drops = 0;
      to_cause = 1'b0;
    end else begin
      n = q.size();
      p = n > 0 && trace_ready_i;
      c = mode == 0 && commit_valid_i && commit_pc_i != 32'd0;
      if (p) void'(q.pop_front());
      if (c) begin
        if (n < DEPTH || p) q.push_back(mk());
        else if (drops < 65535) drops++;
      end
      if (mode == 0) begin
        if (c && commit_instr_i == HALT) begin
          mode = 1;
          to_cause = 1'b0;
        end else if (cyc == TO - 1) begin
          mode = 1;
          to_cause = 1'b1;
        end
        cyc++;
      end else if (mode == 1 && n == 0) mode = 2;
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic commit(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                        input logic [31:0] rdata, input logic rwe, input logic re, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
    commit_valid_i = 1'b1;
    commit_pc_i = pc;
    commit_instr_i = instr;
    commit_rd_i = rd;
    commit_rd_data_i = rdata;
    commit_rd_we_i = rwe;
    commit_mem_re_i = re;
    commit_mem_we_i = we;
    commit_mem_addr_i = addr;
    commit_mem_wdata_i = wdata;
    commit_mem_size_i = size;
  endtask
  task automatic rc(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] rdata);
    commit(pc, 32'h00000013, rd, rdata, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
  endtask
  task automatic idle();
    commit(32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    commit_valid_i = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle();
    step(2);
    rst = 1'b0;
  endtask
  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound && level_o != 0; i++) step();
    chk("drain_bound", level_o, 0);
  endtask
  initial begin
    idle();
    trace_ready_i = 1'b0;
    do_reset();
    chk("rst_level", level_o, 0);
    chk("rst_valid", trace_valid_o, 0);
    chk("rst_drop", drop_count_o, 0);
    chk("rst_halt", halt_o, 0);
    chk("rst_timeout", timeout_o, 0);
    trace_ready_i = 1'b1;
    commit(32'h80000004, 32'h01000293, 5'd5, 32'h10, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    step();
    idle();
    chk("addi_valid", trace_valid_o, 1);
    chk("addi_kind", trace_kind_o, 1);
    chk("addi_rd", trace_rd_o, 5);
    chk("addi_data", trace_data_o, 32'h00000010);
    step();
    chk("addi_popped", level_o, 0);
    trace_ready_i = 1'b0;
    commit(32'h80000010, 32'h00f50023, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h80001000, 32'hDEADBEEF, 2'd0);
    step();
    commit(32'h80000014, 32'h00052003, 5'd0, 32'h1234, 1'b1, 1'b1, 1'b0, 32'h80001004, 32'd0, 2'd2);
    step();
    commit(32'h80000018, 32'h00f51023, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h80001008, 32'hDEADBEEF, 2'd1);
    step();
    commit(32'h8000001c, 32'h00052383, 5'd7, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 32'h8000100c, 32'd0, 2'd2);
    step();
    idle();
    step();
    chk("sb_kind", trace_kind_o, 3);
    chk("sb_data", trace_data_o, 32'h000000EF);
    chk("sb_size", trace_size_o, 0);
    chk("sb_rd", trace_rd_o, 0);
    chk("sb_addr", trace_addr_o, 32'h80001000);
    trace_ready_i = 1'b1;
    step();
    chk("ld_x0_kind", trace_kind_o, 0);
    chk("ld_x0_addr", trace_addr_o, 0);
    step();
    chk("sh_data", trace_data_o, 32'h0000BEEF);
    chk("sh_size", trace_size_o, 1);
    step();
    chk("lw_kind", trace_kind_o, 2);
    chk("lw_rd", trace_rd_o, 7);
    step();
    chk("mem_empty", level_o, 0);
    do_reset();
    trace_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      rc(32'h80000100 + 32'(4 * i), 5'(i + 1), 32'(i));
      step();
    end
    idle();
    chk("full_level", level_o, DEPTH);
    chk("full_drops", drop_count_o, 3);
    trace_ready_i = 1'b1;
    rc(32'h80000200, 5'd9, 32'h99);
    step();
    idle();
    chk("pushpop_level", level_o, DEPTH);
    chk("pushpop_drops", drop_count_o, 3);
    chk("pushpop_head", trace_pc_o, 32'h80000104);
    wait_empty(20);
    do_reset();
    trace_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rc(32'h80000300 + 32'(4 * i), 5'd2, 32'(i));
      step();
    end
    commit(32'h8000030c, HALT, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    step();
    rc(32'h80000310, 5'd3, 32'h5);
    step();
    chk("halt_level", level_o, 4);
    last_instr = 32'd0;
    for (int i = 0; i < 40 && level_o != 0; i++) begin
      trace_ready_i = (i % 2) == 0;
      if (trace_valid_o && trace_ready_i) last_instr = trace_instr_o;
      rc(32'h80000400 + 32'(4 * i), 5'd3, 32'(i));
      step();
    end
    chk("halt_drained", level_o, 0);
    chk("halt_last", last_instr, HALT);
    chk("halt_early", halt_o, 0);
    step();
    chk("halt_done", halt_o, 1);
    chk("halt_no_to", timeout_o, 0);
    chk("halt_ignored", level_o, 0);
    idle();
    do_reset();
    trace_ready_i = 1'b0;
    rc(32'h80000500, 5'd1, 32'h1);
    step();
    rc(32'h80000504, 5'd2, 32'h2);
    step();
    idle();
    step(47);
    rc(32'h80000508, 5'd3, 32'h3);
    step();
    rc(32'h8000050c, 5'd4, 32'h4);
    step();
    idle();
    chk("to_level", level_o, 3);
    chk("to_pending", timeout_o, 0);
    trace_ready_i = 1'b1;
    wait_empty(20);
    step();
    chk("to_done", timeout_o, 1);
    chk("to_no_halt", halt_o, 0);
    do_reset();
    trace_ready_i = 1'b0;
    rc(32'h80000600, 5'd1, 32'h1);
    step();
    rc(32'h80000604, 5'd2, 32'h2);
    step();
    idle();
    step(50);
    chk("drain_level", level_o, 2);
    rst = 1'b1;
    step();
    chk("mid_rst_level", level_o, 0);
    chk("mid_rst_valid", trace_valid_o, 0);
    chk("mid_rst_kind", trace_kind_o, 0);
    chk("mid_rst_timeout", timeout_o, 0);
    rst = 1'b0;
    rc(32'h80000700, 5'd6, 32'h6);
    step();
    idle();
    chk("run_after_rst", level_o, 1);
    commit(32'd0, 32'h00000013, 5'd8, 32'h8, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    step();
    idle();
    chk("pc0_ignored", level_o, 1);
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Synthesizable retirement-trace capture block that sits beside core_model's commit port. It classifies each retired instruction into a log record (REG / LOAD / STORE / NONE) and buffers records in a parametrised FIFO. Records drain over a valid/ready stream to an on-chip or bench-side log sink. Halt-loop detection and timeout are handled by an internal run/drain/done state machine, so end-of-test is signalled in hardware rather than by the bench.

Parameters:
XLEN, 32, datapath width of pc/instr/data/address fields
DEPTH, 16, FIFO entries; power of two, >= 2
TIMEOUT_CYCLES, 10000, cycles in RUN before forced drain; 0 disables timeout
HALT_INSTR, 32'h0000006f, instruction word that marks end of test

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
commit_valid_i  in  1  one instruction retires this cycle
commit_pc_i  in  XLEN  retired pc
commit_instr_i  in  32  retired instruction word
commit_rd_i  in  5  destination register
commit_rd_data_i  in  XLEN  value written to rd
commit_rd_we_i  in  1  register-file write enable
commit_mem_re_i  in  1  load performed
commit_mem_we_i  in  1  store performed
commit_mem_addr_i  in  XLEN  load/store address
commit_mem_wdata_i  in  XLEN  store data
commit_mem_size_i  in  2  0=byte, 1=half, 2=word
trace_valid_o  out  1  head record valid
trace_ready_i  in  1  sink accepts head record
trace_kind_o  out  2  0=NONE, 1=REG, 2=LOAD, 3=STORE
trace_pc_o  out  XLEN  record pc
trace_instr_o  out  32  record instruction
trace_rd_o  out  5  rd (0 for NONE/STORE)
trace_data_o  out  XLEN  rd data (REG/LOAD) or masked store data (STORE)
trace_addr_o  out  XLEN  memory address (LOAD/STORE), else 0
trace_size_o  out  2  store size, else 0
level_o  out  $clog2(DEPTH)+1  current FIFO occupancy
drop_count_o  out  16  records lost to overflow, saturating
halt_o  out  1  halt seen and FIFO drained (sticky)
timeout_o  out  1  timeout fired and FIFO drained (sticky)

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, state RUN, cycle counter 0. All outputs 0: trace_valid_o, level_o, drop_count_o, halt_o, timeout_o; trace_* fields read 0. Reset mid-drain discards all buffered records.
- Capture: commit_valid_i=1 with commit_pc_i != 0 forms a record. Classification is priority-ordered:
  - STORE: mem_we=1.
  - LOAD: mem_re=1 and rd != 0.
  - REG: rd_we=1 and rd != 0.
  - Otherwise NONE.
- Store data is masked to size: byte keeps [7:0], half keeps [15:0], upper bits 0. Size 3 is treated as word.
- Latency: a record is pushed at the edge where it is sampled. trace_valid_o rises the next cycle when the FIFO was empty. There is no combinational bypass.
- Handshake:
  - Pop occurs on an edge where trace_valid_o & trace_ready_i.
  - Head fields hold stable while trace_valid_o=1 and ready=0.
  - trace_valid_o never drops without a pop.
- Full:
  - Push with no pop while level=DEPTH drops the new record and increments drop_count_o, saturating at 16'hFFFF.
  - Push and pop in the same cycle while full: both succeed, level stays DEPTH.
  - Push and pop at level 0 cannot occur, because a pop requires valid.
- Pointers: wrap modulo DEPTH. level_o counts 0..DEPTH inclusive.
- State machine:
  - RUN: capture enabled; cycle counter increments each cycle.
    - Committed instr == HALT_INSTR: that record is still captured, then go to DRAIN with cause=HALT.
    - TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES-1: go to DRAIN with cause=TIMEOUT. A commit in that same cycle is still captured.
    - Halt and timeout in the same cycle: HALT wins.
  - DRAIN: all further commits are ignored (no push, no drop count). Pop continues. When level reaches 0, go to DONE.
  - DONE: halt_o or timeout_o (per cause) asserts the cycle after entry and stays 1 until rst. Capture stays disabled.
- Counter does not advance outside RUN.

Test Plan:
- Reset then ADDI x5 committed (pc=0x80000004, rd=5, data=0x10, rd_we=1), ready=1 -> one cycle later valid=1, kind=1, rd=5, data=0x00000010; popped next edge, level returns 0.
- SB at pc=0x80000010, addr=0x80001000, wdata=0xDEADBEEF, size=0 -> kind=3, data=0x000000EF, size=0, rd=0; LOAD to rd=0 -> kind=0.
- ready=0 with DEPTH+3 back-to-back commits -> level=DEPTH, drop_count=3. Then push+pop in the same cycle -> level stays DEPTH, no extra drop.
- Commit 0x0000006f with 4 records queued, ready toggling 1/0 -> halt record is last out, later commits ignored, halt_o=1 the cycle after level hits 0, timeout_o=0.
- TIMEOUT_CYCLES=50, no halt -> DRAIN entered after 50 RUN cycles, timeout_o=1 once drained. Assert rst while level=2 in DRAIN -> all outputs 0 next cycle, state RUN.
- commit_pc_i=0 with valid=1 -> no record, level unchanged.
